// File: rtl/fft8_stream_seq.sv
// fft8_stream_seq
// Sequential 8-point radix-2 decimation-in-time FFT/IFFT for real samples.
// Eight samples arrive over a valid/ready stream and are stored in bit-reversed
// order. One shared butterfly then runs the 12 butterflies in place, one per
// cycle. The 8 complex bins are emitted serially in natural order over a
// second valid/ready stream.
//
// Parameters
//   DATA_W  signed input sample width
//   TW_W    twiddle width, signed Q1.(TW_W-1)
//   OUT_W   output and internal width (3 stages of bit growth)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, aborts any frame in flight
//   in_valid   sample valid
//   in_ready   sample accepted this cycle if in_valid (high only while loading)
//   in_data    signed real sample x[n]
//   in_inverse mode, sampled with x[0]: 0 = FFT, 1 = IFFT (unscaled)
//   out_valid  bin valid
//   out_ready  downstream accepts bin
//   out_re     signed Re X[k]
//   out_im     signed Im X[k]
//   out_idx    bin index k
module fft8_stream_seq #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16,
    parameter int OUT_W  = DATA_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_inverse,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_re,
    output logic [OUT_W-1:0]  out_im,
    output logic [2:0]        out_idx
);

    // Product width: twiddle times a sum/difference formed one bit wider than OUT_W.
    localparam int PW = TW_W + OUT_W + 1;

    // cos(pi/4) in Q1.(TW_W-1), rounded to nearest.
    localparam logic signed [TW_W-1:0] TW_C =
        TW_W'($rtoi(0.70710678 * (2.0 ** (TW_W - 1)) + 0.5));

    // Half an LSB of the twiddle scale, for round-half-up.
    localparam logic signed [PW-1:0] RND_K =
        {{(PW - TW_W + 1){1'b0}}, 1'b1, {(TW_W - 2){1'b0}}};

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    // 3-bit bit reversal used for the load address.
    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    // Round-half-up rescale of a twiddle product back to OUT_W.
    function automatic logic signed [OUT_W-1:0] rnd(input logic signed [PW-1:0] p);
        return OUT_W'((p + RND_K) >>> (TW_W - 1));
    endfunction

    // Butterfly schedule: {top[2:0], bottom[2:0], twiddle exponent[1:0]}.
    // Stage 1 span 1, stage 2 span 2, stage 3 span 4; groups and pairs ascending.
    function automatic logic [7:0] bf_sched(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd0:    r = {3'd0, 3'd1, 2'd0};
            4'd1:    r = {3'd2, 3'd3, 2'd0};
            4'd2:    r = {3'd4, 3'd5, 2'd0};
            4'd3:    r = {3'd6, 3'd7, 2'd0};
            4'd4:    r = {3'd0, 3'd2, 2'd0};
            4'd5:    r = {3'd1, 3'd3, 2'd2};
            4'd6:    r = {3'd4, 3'd6, 2'd0};
            4'd7:    r = {3'd5, 3'd7, 2'd2};
            4'd8:    r = {3'd0, 3'd4, 2'd0};
            4'd9:    r = {3'd1, 3'd5, 2'd1};
            4'd10:   r = {3'd2, 3'd6, 2'd2};
            4'd11:   r = {3'd3, 3'd7, 2'd3};
            default: r = {3'd0, 3'd1, 2'd0};
        endcase
        return r;
    endfunction

    state_t state_r;
    state_t state_s;

    logic                    in_ready_r;
    logic                    out_valid_r;
    logic signed [OUT_W-1:0] out_re_r;
    logic signed [OUT_W-1:0] out_im_r;
    logic [2:0]              out_idx_r;
    logic [2:0]              load_cnt_r;
    logic [3:0]              bf_cnt_r;
    logic                    inverse_r;
    logic signed [OUT_W-1:0] buf_re_r [8];
    logic signed [OUT_W-1:0] buf_im_r [8];

    logic                    accept_s;
    logic                    out_xfer_s;
    logic [2:0]              nxt_idx_s;
    logic [7:0]              sched_s;
    logic [2:0]              top_s;
    logic [2:0]              bot_s;
    logic [1:0]              tw_s;
    logic signed [OUT_W-1:0] a_re_s;
    logic signed [OUT_W-1:0] a_im_s;
    logic signed [OUT_W-1:0] b_re_s;
    logic signed [OUT_W-1:0] b_im_s;
    logic signed [OUT_W:0]   apb_s;
    logic signed [OUT_W:0]   bma_s;
    logic signed [PW-1:0]    p_apb_s;
    logic signed [PW-1:0]    p_bma_s;
    logic signed [OUT_W-1:0] wb_re_s;
    logic signed [OUT_W-1:0] wb_im_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_re    = out_re_r;
    assign out_im    = out_im_r;
    assign out_idx   = out_idx_r;

    // Handshake qualifiers and the next output address.
    always_comb begin
        accept_s   = in_valid && in_ready_r;
        out_xfer_s = out_valid_r && out_ready;
        nxt_idx_s  = out_idx_r + 3'd1;
    end

    // Next-state logic for LOAD -> COMPUTE -> OUTPUT -> LOAD.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && (load_cnt_r == 3'd7)) begin
                    state_s = ST_COMPUTE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                if (bf_cnt_r == 4'd11) begin
                    state_s = ST_OUTPUT;
                end else begin
                    state_s = ST_COMPUTE;
                end
            end
            ST_OUTPUT: begin
                if (out_xfer_s && (out_idx_r == 3'd7)) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_OUTPUT;
                end
            end
            default: state_s = ST_LOAD;
        endcase
    end

    // State register; in_ready is registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_LOAD;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == ST_LOAD);
        end
    end

    // Operand fetch for the butterfly scheduled this cycle.
    always_comb begin
        sched_s = bf_sched(bf_cnt_r);
        top_s   = sched_s[7:5];
        bot_s   = sched_s[4:2];
        tw_s    = sched_s[1:0];
        a_re_s  = buf_re_r[top_s];
        a_im_s  = buf_im_r[top_s];
        b_re_s  = buf_re_r[bot_s];
        b_im_s  = buf_im_r[bot_s];
        // a+b and b-a of the bottom operand, one bit wider so they cannot wrap.
        apb_s   = {b_re_s[OUT_W-1], b_re_s} + {b_im_s[OUT_W-1], b_im_s};
        bma_s   = {b_im_s[OUT_W-1], b_im_s} - {b_re_s[OUT_W-1], b_re_s};
        p_apb_s = PW'(TW_C) * PW'(apb_s);
        p_bma_s = PW'(TW_C) * PW'(bma_s);
    end

    // Twiddle multiply W*B. Inverse mode uses conj(W): W1->W7, W2->W6, W3->W5.
    always_comb begin
        wb_re_s = b_re_s;
        wb_im_s = b_im_s;
        case (tw_s)
            2'd0: begin
                wb_re_s = b_re_s;
                wb_im_s = b_im_s;
            end
            2'd1: begin
                if (inverse_r) begin
                    wb_re_s = rnd(-p_bma_s);
                    wb_im_s = rnd(p_apb_s);
                end else begin
                    wb_re_s = rnd(p_apb_s);
                    wb_im_s = rnd(p_bma_s);
                end
            end
            2'd2: begin
                // Multiplication by -j (or +j when inverse) is exact.
                if (inverse_r) begin
                    wb_re_s = -b_im_s;
                    wb_im_s = b_re_s;
                end else begin
                    wb_re_s = b_im_s;
                    wb_im_s = -b_re_s;
                end
            end
            2'd3: begin
                if (inverse_r) begin
                    wb_re_s = rnd(-p_apb_s);
                    wb_im_s = rnd(-p_bma_s);
                end else begin
                    wb_re_s = rnd(p_bma_s);
                    wb_im_s = rnd(-p_apb_s);
                end
            end
            default: begin
                wb_re_s = b_re_s;
                wb_im_s = b_im_s;
            end
        endcase
    end

    // Sample buffer, counters, in-place butterflies and registered output bins.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_r  <= 3'd0;
            bf_cnt_r    <= 4'd0;
            inverse_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_re_r    <= '0;
            out_im_r    <= '0;
            out_idx_r   <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                buf_re_r[i] <= '0;
                buf_im_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_LOAD: begin
                    bf_cnt_r <= 4'd0;
                    if (accept_s) begin
                        buf_re_r[bitrev3(load_cnt_r)] <= OUT_W'($signed(in_data));
                        buf_im_r[bitrev3(load_cnt_r)] <= '0;
                        if (load_cnt_r == 3'd0) begin
                            inverse_r <= in_inverse;
                        end
                        load_cnt_r <= load_cnt_r + 3'd1;
                    end
                end
                ST_COMPUTE: begin
                    buf_re_r[top_s] <= a_re_s + wb_re_s;
                    buf_im_r[top_s] <= a_im_s + wb_im_s;
                    buf_re_r[bot_s] <= a_re_s - wb_re_s;
                    buf_im_r[bot_s] <= a_im_s - wb_im_s;
                    bf_cnt_r        <= bf_cnt_r + 4'd1;
                end
                ST_OUTPUT: begin
                    if (!out_valid_r) begin
                        // First cycle of OUTPUT: present bin 0.
                        out_valid_r <= 1'b1;
                        out_idx_r   <= 3'd0;
                        out_re_r    <= buf_re_r[0];
                        out_im_r    <= buf_im_r[0];
                    end else if (out_xfer_s) begin
                        if (out_idx_r == 3'd7) begin
                            out_valid_r <= 1'b0;
                        end else begin
                            out_idx_r <= nxt_idx_s;
                            out_re_r  <= buf_re_r[nxt_idx_s];
                            out_im_r  <= buf_im_r[nxt_idx_s];
                        end
                    end
                end
                default: begin
                    load_cnt_r <= 3'd0;
                end
            endcase
        end
    end

endmodule
